// File: rtl/uart_char_receiver.sv
// 8N1 UART receiver: synchronises RX, samples each bit at mid-bit and
// presents good bytes on char with a newChar strobe; bad stop bits pulse frameError.
module uart_char_receiver #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_RX,
    output logic [7:0] char,
    output logic       newChar,
    output logic       frameError,
    output logic       busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    char_q, char_d;
    logic          new_q, new_d;
    logic          ferr_q, ferr_d;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            char_q  <= '0;
            new_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], UART_RX};
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            char_q  <= char_d;
            new_q   <= new_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        char_d  = char_q;
        new_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cyc_d   = '0;
                end
            end
            START: begin
                if (cyc_q == HALF_M1) begin
                    cyc_d = '0;
                    bit_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            DATA: begin
                if (cyc_q == BIT_M1) begin
                    shift_d[bit_q] = rx_s;
                    cyc_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            STOP: begin
                if (cyc_q == BIT_M1) begin
                    cyc_d = '0;
                    if (rx_s) begin
                        char_d  = shift_q;
                        new_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            BREAK: begin
                // Wait out a held-low line so it cannot re-trigger a frame
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign char       = char_q;
    assign newChar    = new_q;
    assign frameError = ferr_q;
    // Busy also covers the strobe cycle, so a frame reads busy until its byte lands
    assign busy       = (state_q != IDLE) || new_q;

endmodule

// File: tb/tb_uart_char_receiver.sv
// Directed bench for uart_char_receiver at 104 and 8 clocks per bit.
module tb_uart_char_receiver;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rx8;
    logic [7:0] char_o;
    logic [7:0] char8;
    logic       nc, fe, busy;
    logic       nc8, fe8, busy8;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    int nc_cnt = 0, nc_cyc = 0, fe_cnt = 0, fe_cyc = 0, both = 0;
    int rise = 0, fall = 0;
    logic [7:0] nc_char = 8'h00;
    logic busy_p = 1'b0;
    int nc8_cnt = 0, nc8_cyc = 0, fe8_cnt = 0;
    logic [7:0] nc8_char = 8'h00;
    int t;

    uart_char_receiver #(.CLKS_PER_BIT(104), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .UART_RX(rx), .char(char_o),
        .newChar(nc), .frameError(fe), .busy(busy)
    );

    uart_char_receiver #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .UART_RX(rx8), .char(char8),
        .newChar(nc8), .frameError(fe8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nc) begin
            nc_cnt++;
            nc_cyc = cyc;
            nc_char = char_o;
        end
        if (fe) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (nc && fe) both++;
        if (busy && !busy_p) rise = cyc;
        if (!busy && busy_p) fall = cyc;
        busy_p = busy;
        if (nc8) begin
            nc8_cnt++;
            nc8_cyc = cyc;
            nc8_char = char8;
        end
        if (fe8) fe8_cnt++;
        if (nc8 && fe8) both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input bit w, input logic v);
        if (w) rx8 = v;
        else rx = v;
    endtask

    // Caller must be sitting on a negedge; returns 10 bit times later.
    task automatic send(input logic [7:0] b, input int cpb, input bit w, input logic stop);
        drive(w, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            drive(w, b[i]);
        end
        repeat (cpb) @(negedge clk);
        drive(w, stop);
        repeat (cpb) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        rx8 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_char", 32'(char_o), 32'h00);
        chk("rst_newChar", 32'(nc), 32'h0);
        chk("rst_frameError", 32'(fe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_char8", 32'(char8), 32'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single 'd'
        t = cyc;
        send(8'h64, 104, 1'b0, 1'b1);
        chk("t1_count", 32'(nc_cnt), 32'd1);
        chk("t1_time", 32'(nc_cyc), 32'(t + 991));
        chk("t1_char", 32'(nc_char), 32'h64);
        chk("t1_busy_rise", 32'(rise), 32'(t + 3));
        chk("t1_busy_fall", 32'(fall), 32'(t + 992));

        // 2: 't' then 's' back-to-back
        t = cyc;
        send(8'h74, 104, 1'b0, 1'b1);
        chk("t2a_count", 32'(nc_cnt), 32'd2);
        chk("t2a_time", 32'(nc_cyc), 32'(t + 991));
        chk("t2a_char", 32'(nc_char), 32'h74);
        send(8'h73, 104, 1'b0, 1'b1);
        chk("t2b_count", 32'(nc_cnt), 32'd3);
        chk("t2b_time", 32'(nc_cyc), 32'(t + 1040 + 991));
        chk("t2b_char", 32'(char_o), 32'h73);
        chk("t2_no_ferr", 32'(fe_cnt), 32'd0);

        // 3: 30-cycle glitch
        t = cyc;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_busy_start", 32'(busy), 32'h1);
        repeat (27) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        chk("t3_busy_mid", 32'(busy), 32'h1);
        @(negedge clk);
        chk("t3_busy_drop", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        chk("t3_no_char", 32'(nc_cnt), 32'd3);
        chk("t3_no_ferr", 32'(fe_cnt), 32'd0);

        // 4: bad stop bit, then held low
        t = cyc;
        send(8'h55, 104, 1'b0, 1'b0);
        chk("t4_ferr_count", 32'(fe_cnt), 32'd1);
        chk("t4_ferr_time", 32'(fe_cyc), 32'(t + 991));
        chk("t4_no_char", 32'(nc_cnt), 32'd3);
        chk("t4_char_kept", 32'(char_o), 32'h73);
        repeat (1896) @(negedge clk);
        chk("t4_busy_low_line", 32'(busy), 32'h1);
        chk("t4_single_ferr", 32'(fe_cnt), 32'd1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_busy_release", 32'(busy), 32'h0);

        // 5: reset during bit 4 of 0xA5, then 0x3C
        rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (104) @(negedge clk);
            rx = (i == 0 || i == 2) ? 1'b1 : 1'b0;
        end
        repeat (52) @(negedge clk);
        chk("t5_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("t5_rst_char", 32'(char_o), 32'h00);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_nc", 32'(nc), 32'h0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_partial", 32'(nc_cnt), 32'd3);
        send(8'h3C, 104, 1'b0, 1'b1);
        chk("t5_count", 32'(nc_cnt), 32'd4);
        chk("t5_char", 32'(nc_char), 32'h3C);

        // 6: 8 clocks per bit, 0xFF then 0x00
        t = cyc;
        send(8'hFF, 8, 1'b1, 1'b1);
        chk("t6a_count", 32'(nc8_cnt), 32'd1);
        chk("t6a_time", 32'(nc8_cyc), 32'(t + 79));
        chk("t6a_char", 32'(nc8_char), 32'hFF);
        send(8'h00, 8, 1'b1, 1'b1);
        chk("t6b_count", 32'(nc8_cnt), 32'd2);
        chk("t6b_time", 32'(nc8_cyc), 32'(t + 159));
        chk("t6b_char", 32'(char8), 32'h00);
        chk("t6_no_ferr", 32'(fe8_cnt), 32'd0);

        chk("never_both", 32'(both), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
